// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int unsigned PC_INC  = 32'd4;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: redirect target, sequential increment or hold.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 64
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] immgen,
  input  logic             taken,
  input  logic             stall,
  input  logic             accept,
  output logic [PC_W-1:0]  next_pc,
  output logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  target
);

  assign pc_plus4 = pc + PC_W'(PC_INC);

  // Sum at immediate width then truncate, so negative offsets wrap modulo 2^PC_W.
  assign target = PC_W'(IMM_W'(pc) + (immgen << 1));

  always_comb begin
    next_pc = pc;
    if (taken) begin
      next_pc = target;
    end else if (!stall && accept) begin
      next_pc = pc_plus4;
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer (BOOT -> FETCH -> sticky HALT).
// Optional saturating statistics counters: define PC_SEQ_BRANCH_STATS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IMM_W    = 64,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic             zero_flag,
  input  logic [IMM_W-1:0] immgen,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus4,
  output logic             flush,
`ifdef PC_SEQ_BRANCH_STATS_EN
  output logic [15:0]      taken_count,
  output logic [15:0]      fetch_count,
`endif
  output logic             halted
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_flush;
  logic            r_halted;

  logic            w_taken;
  logic            w_accept;
  logic            w_redirect;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_target;

  // Request is state-decoded so a stall withdraws it in the same cycle.
  assign imem_req   = (r_state == FETCH) && !stall;
  assign w_taken    = branch & zero_flag;
  assign w_accept   = imem_req & imem_ready;
  assign w_redirect = (r_state == FETCH) && !halt && w_taken;

  pc_next_calc #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_next (
    .pc       (r_pc),
    .immgen   (immgen),
    .taken    (w_taken),
    .stall    (stall),
    .accept   (w_accept),
    .next_pc  (w_next_pc),
    .pc_plus4 (pc_plus4),
    .target   (w_target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
          r_flush <= 1'b0;
        end
        FETCH: begin
          if (halt) begin
            r_state  <= HALT;
            r_flush  <= 1'b0;
            r_halted <= 1'b1;
          end else if (w_taken) begin
            r_pc    <= w_target;
            r_flush <= 1'b1;
          end else begin
            r_pc    <= w_next_pc;
            r_flush <= 1'b0;
          end
        end
        HALT: begin
          r_flush  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= BOOT;
          r_flush  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_fetch_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken_cnt <= 16'd0;
      r_fetch_cnt <= 16'd0;
    end else begin
      if (w_redirect && (r_taken_cnt != SAT_MAX)) begin
        r_taken_cnt <= r_taken_cnt + 16'd1;
      end
      if (w_accept && (r_fetch_cnt != SAT_MAX)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
    end
  end

  assign taken_count = r_taken_cnt;
  assign fetch_count = r_fetch_cnt;
`else
  logic w_unused;
  assign w_unused = w_redirect;
`endif

  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign flush     = r_flush;
  assign halted    = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W=8, IMM_W=64, RESET_PC=0).
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        branch;
  logic        zero_flag;
  logic [63:0] immgen;
  logic        imem_ready;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [7:0]  pc;
  logic [7:0]  pc_plus4;
  logic        flush;
  logic        halted;
`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] fetch_count;
`endif

  int total;
  int bad;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .halt       (halt),
    .branch     (branch),
    .zero_flag  (zero_flag),
    .immgen     (immgen),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .flush      (flush),
`ifdef PC_SEQ_BRANCH_STATS_EN
    .taken_count(taken_count),
    .fetch_count(fetch_count),
`endif
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; stall = 1'b0; halt = 1'b0; branch = 1'b0; zero_flag = 1'b0;
    immgen = 64'd0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    reset = 1'b0; #1;
    chk("boot_req", 32'(imem_req), 32'h0);
    tick(); chk("seq_addr00", 32'(imem_addr), 32'h00); chk("seq_req", 32'(imem_req), 32'h1);
    tick(); chk("seq_addr04", 32'(imem_addr), 32'h04);
    tick(); chk("seq_addr08", 32'(imem_addr), 32'h08);
    tick(); chk("seq_addr0C", 32'(imem_addr), 32'h0C);

    #2 reset = 1'b1;
    #1 chk("async_rst_pc", 32'(pc), 32'h00);
    chk("async_rst_req", 32'(imem_req), 32'h0);
    tick(); reset = 1'b0;
    tick(); chk("reboot_pc", 32'(pc), 32'h00);
    repeat (4) tick();
    chk("pc10", 32'(pc), 32'h10);

    imem_ready = 1'b0; #1;
    chk("bp1_req", 32'(imem_req), 32'h1); chk("bp1_addr", 32'(imem_addr), 32'h10);
    tick(); chk("bp2_req", 32'(imem_req), 32'h1); chk("bp2_addr", 32'(imem_addr), 32'h10);
    tick(); chk("bp3_req", 32'(imem_req), 32'h1); chk("bp3_addr", 32'(imem_addr), 32'h10);
    imem_ready = 1'b1;
    tick(); chk("bp_release", 32'(pc), 32'h14);
    repeat (3) tick();
    chk("pc20", 32'(pc), 32'h20);

    branch = 1'b1; zero_flag = 1'b1; immgen = 64'd6;
    tick(); chk("br_pc2C", 32'(pc), 32'h2C); chk("br_flush1", 32'(flush), 32'h1);
    immgen = 64'hFFFF_FFFF_FFFF_FFFA;
    tick(); chk("br_back_pc20", 32'(pc), 32'h20); chk("br_back_flush", 32'(flush), 32'h1);
    zero_flag = 1'b0;
    tick(); chk("nt_pc24", 32'(pc), 32'h24); chk("nt_flush0", 32'(flush), 32'h0);
    zero_flag = 1'b1; immgen = 64'hFFFF_FFFF_FFFF_FFF0;
    tick(); chk("neg_pc04", 32'(pc), 32'h04);
    immgen = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); chk("wrap_pcFC", 32'(pc), 32'hFC); chk("wrap_plus4", 32'(pc_plus4), 32'h00);
    branch = 1'b0;
    tick(); chk("wrap_pc00", 32'(pc), 32'h00); chk("wrap_flush0", 32'(flush), 32'h0);
    branch = 1'b1; immgen = 64'h18;
    tick(); chk("pc30", 32'(pc), 32'h30);

    stall = 1'b1; immgen = 64'd2; #1;
    chk("stbr_req", 32'(imem_req), 32'h0);
    tick(); chk("stbr_pc34", 32'(pc), 32'h34); chk("stbr_flush", 32'(flush), 32'h1);
    branch = 1'b0; #1;
    chk("stall_req", 32'(imem_req), 32'h0);
    tick(); chk("stall_pc", 32'(pc), 32'h34); chk("stall_flush", 32'(flush), 32'h0);
    stall = 1'b0; branch = 1'b1; immgen = 64'd6;
    tick(); chk("pc40", 32'(pc), 32'h40);

    halt = 1'b1; immgen = 64'd2;
    tick();
    chk("halt_pc", 32'(pc), 32'h40); chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_flush", 32'(flush), 32'h0); chk("halt_req", 32'(imem_req), 32'h0);
`ifdef PC_SEQ_BRANCH_STATS_EN
    chk("halt_taken_cnt", 32'(taken_count), 32'd7);
`endif
    halt = 1'b0; branch = 1'b0;
    tick(); chk("halt_sticky_pc", 32'(pc), 32'h40); chk("halt_sticky", 32'(halted), 32'h1);
    reset = 1'b1; #1;
    chk("halt_exit_rst", 32'(halted), 32'h0);
    tick(); reset = 1'b0;

`ifdef PC_SEQ_BRANCH_STATS_EN
    branch = 1'b1; zero_flag = 1'b1; immgen = 64'd2; imem_ready = 1'b1;
    repeat (65540) tick();
    chk("sat_taken", 32'(taken_count), 32'hFFFF);
    chk("sat_fetch", 32'(fetch_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and sequences instruction fetch for the single-issue core.
- Each cycle it selects the next PC: sequential PC+4, taken-branch target (PC + imm<<1), or hold on stall, fetch backpressure or halt.
- Drives a request/ready fetch handshake toward instruction memory.
- Pulses a flush to the decode stage on every taken redirect.

Parameters:
PC_W, 8, program counter width in bits; all PC arithmetic is modulo 2^PC_W.
IMM_W, 64, width of the sign-extended immediate from immediate generation.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard stall from decode; freezes PC and suppresses fetch.
halt  input  1  enters the sticky HALT state.
branch  input  1  branch instruction in execute.
zero_flag  input  1  ALU zero result for the branch in execute.
immgen  input  IMM_W  immediate of the branch in execute.
imem_ready  input  1  instruction memory accepts the current request.
imem_req  output  1  fetch request valid.
imem_addr  output  PC_W  fetch address, equal to pc.
pc  output  PC_W  current program counter.
pc_plus4  output  PC_W  pc+4, for link-register writeback.
flush  output  1  one-cycle pulse meaning "discard the instruction fetched before the redirect".
halted  output  1  high while in HALT.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - pc=RESET_PC, state=BOOT.
  - imem_req=0, flush=0, halted=0.
- FSM states:
  - BOOT: imem_req=0 for exactly one cycle, then goes to FETCH unconditionally. Branch/stall/halt are ignored in BOOT.
  - FETCH: imem_req = !stall; imem_addr = pc.
  - HALT: imem_req=0, halted=1, pc frozen. Only reset exits HALT.
- Transitions out of FETCH:
  - halt=1 goes to HALT next cycle. Halt outranks all other updates; pc is not updated that cycle.
- Taken branch: taken = branch & zero_flag, sampled in FETCH.
- Target arithmetic:
  - target = (pc + {immgen[IMM_W-2:0],1'b0}) truncated to the low PC_W bits.
  - Negative immediates wrap naturally.
  - pc+4 wraps: PC_W=8 gives 8'hFC+4 = 8'h00.
- PC update priority in FETCH (highest first):
  1. halt.
  2. taken: pc <= target next cycle; flush=1 for exactly the following cycle. This applies regardless of stall or imem_ready. An unaccepted request is abandoned, and memory must tolerate request withdrawal.
  3. stall: pc holds; imem_req=0.
  4. imem_req & imem_ready: pc <= pc+4.
  5. imem_req & !imem_ready: pc and imem_addr held stable; imem_req stays 1.
- Back-to-back taken branches each redirect and each produce a one-cycle flush pulse. Flush may therefore be high on consecutive cycles.
- Latency:
  - Redirect reaches imem_addr 1 cycle after taken is sampled.
  - First fetch request is issued 1 cycle after reset deassertion (BOOT cycle).
- pc_plus4 is combinational from pc; all other outputs are registered or state-decoded.

Optional Feature:
- Macro: PC_SEQ_BRANCH_STATS_EN.
- Defined:
  - Adds outputs taken_count[15:0] and fetch_count[15:0].
  - Both are saturating counters, cleared by reset.
  - taken_count increments on each taken redirect; fetch_count increments on each accepted request (imem_req & imem_ready).
  - Both hold at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pc_seq_pkg holds:
  - the state enum (BOOT, FETCH, HALT);
  - the constants PC_INC=4 and SAT_MAX=16'hFFFF.
- One combinational sub-module, pc_next_calc:
  - Inputs: pc, immgen, taken, stall, accept.
  - Outputs: next_pc, pc_plus4, target.
- The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then idle, with imem_ready=1 tied and no branches:
  - imem_req=0 in the BOOT cycle.
  - imem_addr = 00, 04, 08, 0C on successive cycles.
  - Assert reset mid-stream: pc=00 immediately, without waiting for a clock edge.
- Backpressure: imem_ready=0 for 3 cycles at pc=10 → imem_req=1 and imem_addr=10 held all 3 cycles; the next cycle after ready=1 gives pc=14.
- Taken branch at pc=20 with immgen=6 → pc=2C next cycle, flush=1 for one cycle. Repeat with branch=1, zero_flag=0 → pc=24, flush stays 0.
- Negative offset and wrap:
  - pc=04, immgen=64'hFFFF_FFFF_FFFF_FFFC → target=FC.
  - Then sequential fetch gives FC, then 00.
- Stall plus branch in the same cycle at pc=30 with immgen=2 → pc=34 and flush=1, so the redirect wins. Stall alone → imem_req=0 and pc holds.
- halt=1 at pc=40 with taken=1 → HALT state, halted=1, pc stays 40, no flush. With PC_SEQ_BRANCH_STATS_EN defined, taken_count is unchanged and saturation at FFFF is checked.
